spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl.sv | 97 +++++++++
 tb/tb_spi_master_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: 10-bit command SPI frame engine with optional read-back capture
module spi_master_ctrl #(
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned GAP     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_data,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic       done,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err
);
  typedef enum logic [2:0] {IDLE, START, SHIFT, WAIT, CAPTURE, END} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  cmd_q, cmd_d;
  logic        ss_n_q, mosi_q, ready_q, done_q, rsp_valid_q, rsp_err_q, addr_loaded_q;
  logic [7:0]  rsp_data_q;
  logic        mosi_d, enter_end, rd_frame;
  assign rd_frame = cmd_q[9:8] == 2'b11;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    case (state_q)
      IDLE: if (cmd_valid && ready_q) begin
        state_d = START;
        cmd_d   = cmd_data;
      end
      START: begin
        state_d = SHIFT;
        cnt_d   = 4'd9;
      end
      SHIFT: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else if (rd_frame) begin
        state_d = (RD_WAIT == 0) ? CAPTURE : WAIT;
        cnt_d   = (RD_WAIT == 0) ? 4'd0 : 4'(RD_WAIT - 1);
      end else begin
        state_d = END;
        cnt_d   = 4'(GAP - 1);
      end
      WAIT: if (cnt_q == 4'd0) state_d = CAPTURE;
      else cnt_d = cnt_q - 4'd1;
      CAPTURE: if (cnt_q == 4'd7) begin
        state_d = END;
        cnt_d   = 4'(GAP - 1);
      end else cnt_d = cnt_q + 4'd1;
      END: if (cnt_q == 4'd0) state_d = IDLE;
      else cnt_d = cnt_q - 4'd1;
      default: state_d = IDLE;
    endcase
    // outputs are registered from the next state so they line up with state_q
    mosi_d    = (state_d == START) ? cmd_d[9] : (state_d == SHIFT) ? cmd_d[cnt_d] : 1'b0;
    enter_end = (state_d == END) && (state_q != END);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_q         <= '0;
      ss_n_q        <= 1'b1;
      mosi_q        <= 1'b0;
      ready_q       <= 1'b0;
      done_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_data_q    <= '0;
      addr_loaded_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_q         <= cmd_d;
      ss_n_q        <= (state_d == IDLE) || (state_d == END);
      mosi_q        <= mosi_d;
      ready_q       <= state_d == IDLE;
      done_q        <= enter_end;
      rsp_valid_q   <= enter_end && rd_frame;
      rsp_err_q     <= enter_end && rd_frame && !addr_loaded_q;
      if (state_q == CAPTURE) rsp_data_q[cnt_q[2:0]] <= MISO;
      addr_loaded_q <= (enter_end && cmd_q[9:8] == 2'b10) ? 1'b1 :
                       (enter_end && rd_frame) ? 1'b0 : addr_loaded_q;
    end
  end
  assign cmd_ready = ready_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign done      = done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: table-driven frame checks plus back-to-back, mid-frame reset and RD_WAIT=0/GAP=3 sequences
module tb_spi_master_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic cmd_valid = 1'b0, cmd_ready, SS_n, MOSI, MISO = 1'b0, done, rsp_valid, rsp_err;
  logic [9:0] cmd_data = '0;
  logic [7:0] rsp_data;
  logic cmd_valid2 = 1'b0, cmd_ready2, SS_n2, MOSI2, MISO2 = 1'b0, done2, rsp_valid2, rsp_err2;
  logic [9:0] cmd_data2 = '0;
  logic [7:0] rsp_data2;
  int checks = 0, errors = 0;

  spi_master_ctrl u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .done(done), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err));

  spi_master_ctrl #(.RD_WAIT(0), .GAP(3)) u_dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_data(cmd_data2),
    .SS_n(SS_n2), .MOSI(MOSI2), .MISO(MISO2), .done(done2), .rsp_valid(rsp_valid2),
    .rsp_data(rsp_data2), .rsp_err(rsp_err2));

  typedef struct {
    logic [9:0]  cmd;
    logic [7:0]  miso;
    int          lows;
    logic [10:0] mosi;
    int          rv;
    logic [7:0]  rd;
    int          re;
    int          rdy;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!cmd_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic run_frame(input logic [9:0] c, input logic [7:0] mb, output int lows,
                           output logic [10:0] seq, output int extra, output int dones,
                           output int rvs, output int re, output int rdy);
    lows = 0; seq = '0; extra = 0; dones = 0; rvs = 0; re = 0; rdy = -1;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_data  = c;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (!SS_n) begin
        lows++;
        if (lows <= 11) seq = {seq[9:0], MOSI};
        else extra += int'(MOSI);
      end
      MISO = (!SS_n && lows >= 14 && lows <= 21) ? mb[lows - 14] : 1'b0;
      dones += int'(done);
      if (rsp_valid) begin
        rvs++;
        re = int'(rsp_err);
      end
      if (cmd_ready) begin
        rdy = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    MISO = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lows, extra, dones, rvs, re, rdy, hs, frames, high, prev_low, adv, dn, highs, done_at;
    logic [10:0] seq;
    logic [9:0] q[3];
    logic [7:0] mb2;
    tbl[0] = '{10'h300, 8'hA5, 21, 11'b111_0000_0000, 1, 8'hA5, 1, 23};
    tbl[1] = '{10'h0A5, 8'h00, 11, 11'b000_1010_0101, 0, 8'h00, 0, 13};
    tbl[2] = '{10'h233, 8'h00, 11, 11'b110_0011_0011, 0, 8'h00, 0, 13};
    tbl[3] = '{10'h300, 8'hC6, 21, 11'b111_0000_0000, 1, 8'hC6, 0, 23};
    tbl[4] = '{10'h300, 8'h3C, 21, 11'b111_0000_0000, 1, 8'h3C, 1, 23};
    tbl[5] = '{10'h1FF, 8'h00, 11, 11'b001_1111_1111, 0, 8'h00, 0, 13};

    #12;
    chk("rst_ss_n", int'(SS_n), 1);
    chk("rst_mosi", int'(MOSI), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_err", int'(rsp_err), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ready_before_release_edge", int'(cmd_ready), 0);
    @(posedge clk); #1;
    chk("ready_after_release", int'(cmd_ready), 1);
    chk("ready2_after_release", int'(cmd_ready2), 1);

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].cmd, tbl[i].miso, lows, seq, extra, dones, rvs, re, rdy);
      chk($sformatf("v%0d_ss_low", i), lows, tbl[i].lows);
      chk($sformatf("v%0d_mosi_seq", i), int'(seq), int'(tbl[i].mosi));
      chk($sformatf("v%0d_mosi_idle_bits", i), extra, 0);
      chk($sformatf("v%0d_done", i), dones, 1);
      chk($sformatf("v%0d_rsp_valid", i), rvs, tbl[i].rv);
      chk($sformatf("v%0d_ready_cycle", i), rdy, tbl[i].rdy);
      if (tbl[i].rv == 1) begin
        chk($sformatf("v%0d_rsp_err", i), re, tbl[i].re);
        chk($sformatf("v%0d_rsp_data", i), int'(rsp_data), int'(tbl[i].rd));
      end
    end

    q[0] = 10'h011; q[1] = 10'h122; q[2] = 10'h033;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_data  = q[0];
    hs = 0; frames = 0; dones = 0; high = 0; prev_low = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      adv = (cmd_valid && cmd_ready) ? 1 : 0;
      hs += adv;
      if (!SS_n) begin
        if (prev_low == 0) begin
          frames++;
          if (frames > 1) chk("b2b_gap", high, 2);
        end
        high = 0;
      end else high++;
      prev_low = SS_n ? 0 : 1;
      dones += int'(done);
      @(posedge clk); #1;
      if (adv == 1) begin
        if (hs < 3) cmd_data = q[hs];
        else cmd_valid = 1'b0;
      end
    end
    chk("b2b_frames", frames, 3);
    chk("b2b_done", dones, 3);
    chk("b2b_handshakes", hs, 3);

    wait_ready();
    cmd_valid = 1'b1;
    cmd_data  = 10'h300;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("abort_ss_low_before", int'(SS_n), 0);
    rst = 1'b1;
    #1;
    chk("abort_ss_n_immediate", int'(SS_n), 1);
    chk("abort_ready", int'(cmd_ready), 0);
    dn = 0;
    repeat (2) begin
      @(posedge clk); #1;
      dn += int'(done) + int'(rsp_valid);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready_after_release", int'(cmd_ready), 1);
    repeat (20) begin
      dn += int'(done) + int'(rsp_valid) + int'(!SS_n);
      @(posedge clk); #1;
    end
    chk("abort_no_pulse", dn, 0);

    mb2 = 8'h5A;
    lows = 0; highs = 0; done_at = 0; rvs = 0; re = 0;
    cmd_valid2 = 1'b1;
    cmd_data2  = 10'h300;
    @(posedge clk); #1;
    cmd_valid2 = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (!SS_n2) lows++;
      else if (lows > 0 && !cmd_ready2) highs++;
      MISO2 = (!SS_n2 && lows >= 12 && lows <= 19) ? mb2[lows - 12] : 1'b0;
      if (done2) done_at = highs;
      if (rsp_valid2) begin
        rvs++;
        re = int'(rsp_err2);
      end
      if (cmd_ready2 && lows > 0) break;
      @(posedge clk); #1;
    end
    chk("w0_ss_low", lows, 19);
    chk("w0_end_cycles", highs, 3);
    chk("w0_done_first_end", done_at, 1);
    chk("w0_rsp_valid", rvs, 1);
    chk("w0_rsp_err", re, 1);
    chk("w0_rsp_data", int'(rsp_data2), 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
